nw_job_sched: RTL

NW_JOB_SCHED -- requirements
Module: nw_job_sched

---
 rtl/nw_job_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/nw_job_sched.sv
// Round-robin job scheduler feeding one Needleman-Wunsch grid from two requesters.
// Optional RUN watchdog enabled by defining NW_TIMEOUT_EN.
module nw_job_sched #(
  parameter int LENGTH     = 10,
  parameter int CWIDTH     = 2,
  parameter int SWIDTH     = 16,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_valid,
  input  logic                       req1_valid,
  output logic                       req0_ready,
  output logic                       req1_ready,
  input  logic [LENGTH*CWIDTH-1:0]   req0_s1,
  input  logic [LENGTH*CWIDTH-1:0]   req0_s2,
  input  logic [LENGTH*CWIDTH-1:0]   req1_s1,
  input  logic [LENGTH*CWIDTH-1:0]   req1_s2,
  output logic [LENGTH*CWIDTH-1:0]   grid_s1,
  output logic [LENGTH*CWIDTH-1:0]   grid_s2,
  output logic                       grid_reset,
  input  logic signed [SWIDTH-1:0]   grid_score,
  input  logic                       grid_valid,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic signed [SWIDTH-1:0]   rsp_score,
  output logic                       rsp_err
);

  localparam int SW = LENGTH * CWIDTH;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  if (CLR_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("nw_job_sched: CLR_CYCLES and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                     r_last;
  logic [CW-1:0]            r_clr;
  logic [SW-1:0]            r_s1;
  logic [SW-1:0]            r_s2;
  logic                     r_id;
  logic signed [SWIDTH-1:0] r_score;

  logic w_idle;
  logic w_g0;
  logic w_g1;
  logic w_acc;
  logic w_run;
  logic w_fin;

  // r_last=1 means requester 1 won last, so requester 0 wins a tie
  assign w_idle = (r_state == S_IDLE);
  assign w_g0   = req0_valid & (~req1_valid | r_last);
  assign w_g1   = req1_valid & (~req0_valid | ~r_last);
  assign w_acc  = w_idle & (w_g0 | w_g1);
  assign w_run  = (r_state == S_RUN);

  assign req0_ready = w_idle & w_g0;
  assign req1_ready = w_idle & w_g1;

`ifdef NW_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_run;
  logic          r_err;
  logic          w_tmo;

  assign w_tmo   = w_run & (r_run == TMO_LAST);
  assign w_fin   = (w_run & grid_valid) | w_tmo;
  assign rsp_err = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= '0;
      r_err <= 1'b0;
    end else begin
      r_run <= w_run ? r_run + 1'b1 : '0;
      if (w_run && grid_valid)
        r_err <= 1'b0;
      else if (w_tmo)
        r_err <= 1'b1;
    end
  end
`else
  assign w_fin   = w_run & grid_valid;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = S_CLEAR;
      S_CLEAR: if (r_clr == '0) w_next = S_RUN;
      S_RUN:   if (w_fin) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last  <= 1'b1;
      r_clr   <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_id    <= 1'b0;
      r_score <= '0;
    end else begin
      if (w_acc) begin
        r_s1   <= w_g0 ? req0_s1 : req1_s1;
        r_s2   <= w_g0 ? req0_s2 : req1_s2;
        r_id   <= w_g1;
        r_last <= w_g1;
        r_clr  <= CLR_LAST;
      end else if (r_state == S_CLEAR && r_clr != '0) begin
        r_clr <= r_clr - 1'b1;
      end
      // a timeout with no grid result reports a zero score
      if (w_run && grid_valid)
        r_score <= grid_score;
      else if (w_fin)
        r_score <= '0;
    end
  end

  assign grid_s1    = r_s1;
  assign grid_s2    = r_s2;
  assign grid_reset = ~w_run;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_score  = r_score;

endmodule
